barrel_shift_pipe: RTL and testbench

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/barrel_shift_pipe.sv | 100 ++++++++++
 tb/tb_barrel_shift_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL) with carry-out and zero flag.
// Each stage resolves one distance bit; the WIDTH-sized step is folded into stage 0.
module barrel_shift_pipe #(
    parameter int WIDTH  = 8,
    parameter int DIST_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in,
    input  logic [DIST_W:0]   distance,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out,
    output logic              carry,
    output logic              zero
);

    // One shift step of s bits on {carry, data}. The carry is the last bit that
    // left the word, so chaining steps yields the carry of the total shift.
    function automatic logic [WIDTH:0] step(input logic [WIDTH:0] cd, input logic [1:0] m,
                                            input int s, input logic en);
        logic [WIDTH-1:0] d, r;
        logic             c;
        d = cd[WIDTH-1:0];
        r = d;
        c = cd[WIDTH];
        if (en) begin
            case (m)
                2'b00: begin
                    r = d << s;
                    c = |(d & (WIDTH'(1) << (WIDTH - s)));
                end
                2'b01: begin
                    r = d >> s;
                    c = |(d & (WIDTH'(1) << (s - 1)));
                end
                2'b10: begin
                    r = $signed(d) >>> s;
                    c = |(d & (WIDTH'(1) << (s - 1)));
                end
                default: begin
                    // Rotation by WIDTH is the identity (distance mod WIDTH).
                    if (s < WIDTH) begin
                        r = (d << s) | (d >> (WIDTH - s));
                        c = r[0];
                    end
                end
            endcase
        end
        return {c, r};
    endfunction

    logic                            advance;
    logic [DIST_W-1:0]               vld_q;
    logic [DIST_W-1:0][WIDTH:0]      cd_q;
    logic [DIST_W-1:0][WIDTH:0]      cd_d;
    logic [DIST_W-1:0][1:0]          mode_q;
    logic [DIST_W-1:0][DIST_W:0]     dist_q;
    logic                            zero_q;
    logic                            unused_ok;

    assign advance  = !vld_q[DIST_W-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        cd_d    = '0;
        cd_d[0] = step(step({1'b0, in}, mode, WIDTH, distance[DIST_W]), mode, 1, distance[0]);
        for (int i = 1; i < DIST_W; i++)
            cd_d[i] = step(cd_q[i-1], mode_q[i-1], 1 << i, dist_q[i-1][i]);
    end

    // The whole pipe moves in lockstep; bubbles travel with their slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            cd_q   <= '0;
            mode_q <= '0;
            dist_q <= '0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q  <= {vld_q[DIST_W-2:0], in_valid};
            cd_q   <= cd_d;
            mode_q <= {mode_q[DIST_W-2:0], mode};
            dist_q <= {dist_q[DIST_W-2:0], distance};
            zero_q <= (cd_d[DIST_W-1][WIDTH-1:0] == '0);
        end
    end

    assign out_valid = vld_q[DIST_W-1];
    assign out       = cd_q[DIST_W-1][WIDTH-1:0];
    assign carry     = cd_q[DIST_W-1][WIDTH];
    assign zero      = zero_q;

    // Residual control bits already consumed by earlier stages.
    assign unused_ok = ^{mode_q[DIST_W-1], dist_q};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed + randomized bench for barrel_shift_pipe (WIDTH=8) against an
// arithmetic reference model and a result queue.
module tb_barrel_shift_pipe;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, carry, zero;
    logic [7:0] din, dout;
    logic [3:0] distance;
    logic [1:0] mode;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] smp_out;
    logic       smp_ov, smp_ir;

    barrel_shift_pipe #(.WIDTH(8), .DIST_W(3)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in(din),
        .distance(distance), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(dout),
        .carry(carry), .zero(zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift inside a wider word and read the bit just past the result.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [3:0] d, input logic [1:0] m);
        logic [15:0] v;
        logic [23:0] w;
        logic [7:0]  o;
        logic        c;
        int          e;
        case (m)
            2'b00: begin v = {8'h00, a} << d; o = v[7:0];  c = v[8]; end
            2'b01: begin v = {a, 8'h00} >> d; o = v[15:8]; c = v[7]; end
            2'b10: begin
                w = $signed({{8{a[7]}}, a, 8'h00}) >>> d;
                o = w[15:8];
                c = w[7];
            end
            default: begin
                e = int'(d) % 8;
                v = {a, a} << e;
                o = v[15:8];
                c = (e != 0) ? o[0] : 1'b0;
            end
        endcase
        return {c, o};
    endfunction

    // One clock cycle: drive, sample mid-cycle, then step past the edge.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic [3:0] dd,
                         input logic [1:0] mm, input logic ordy, output logic acc);
        logic       fo;
        logic [8:0] e;
        in_valid = iv; din = id; distance = dd; mode = mm; out_ready = ordy;
        #1;
        smp_ov = out_valid; smp_ir = in_ready; smp_out = dout;
        chk("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
        if (out_valid) begin
            if (exp_q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'(0));
            else begin
                e = exp_q[0];
                chk("out", 32'(dout), 32'(e[7:0]));
                chk("carry", 32'(carry), 32'(e[8]));
                chk("zero", 32'(zero), 32'(e[7:0] == 8'h00));
            end
        end
        acc = iv && in_ready;
        fo  = out_valid && ordy;
        @(posedge clock);
        if (acc) exp_q.push_back(model(id, dd, mm));
        if (fo) begin
            got_q.push_back(smp_out);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        #1;
    endtask

    task automatic single(input logic [7:0] a, input logic [3:0] d, input logic [1:0] m,
                          input logic [7:0] eo, input logic ec, input string tag);
        logic acc;
        cycle(1'b1, a, d, m, 1'b1, acc);
        chk({tag, "_accept"}, 32'(acc), 32'(1));
        chk({tag, "_lat1"}, 32'(out_valid), 32'(0));
        cycle(1'b0, 8'h00, 4'd0, 2'b00, 1'b1, acc);
        chk({tag, "_lat2"}, 32'(out_valid), 32'(0));
        cycle(1'b0, 8'h00, 4'd0, 2'b00, 1'b1, acc);
        chk({tag, "_lat3"}, 32'(out_valid), 32'(1));
        chk({tag, "_out"}, 32'(dout), 32'(eo));
        chk({tag, "_carry"}, 32'(carry), 32'(ec));
        chk({tag, "_zero"}, 32'(zero), 32'(eo == 8'h00));
        cycle(1'b0, 8'h00, 4'd0, 2'b00, 1'b1, acc);
    endtask

    initial begin
        logic       acc, pend;
        logic [7:0] pa;
        logic [3:0] pd;
        logic [1:0] pm;
        int         idx;

        reset = 1'b1; in_valid = 1'b0; din = 8'h00; distance = 4'd0; mode = 2'b00; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out", 32'(dout), 32'(0));
        chk("rst_carry", 32'(carry), 32'(0));
        chk("rst_zero", 32'(zero), 32'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        single(8'h81, 4'd1,  2'b00, 8'h02, 1'b1, "lsl_81_1");
        single(8'h90, 4'd3,  2'b10, 8'hF2, 1'b0, "asr_90_3");
        single(8'h90, 4'd12, 2'b10, 8'hFF, 1'b1, "asr_90_12");
        single(8'h90, 4'd8,  2'b01, 8'h00, 1'b1, "lsr_90_8");
        single(8'h90, 4'd9,  2'b01, 8'h00, 1'b0, "lsr_90_9");
        single(8'h81, 4'd4,  2'b11, 8'h18, 1'b0, "rol_81_4");
        single(8'h81, 4'd9,  2'b11, 8'h03, 1'b1, "rol_81_9");
        single(8'h81, 4'd8,  2'b11, 8'h81, 1'b0, "rol_81_8");
        single(8'h81, 4'd8,  2'b00, 8'h00, 1'b1, "lsl_81_8");
        single(8'h81, 4'd0,  2'b01, 8'h81, 1'b0, "lsr_81_0");

        // Back-to-back LSL 1 of 0x01..0x05, consumer stalled cycles 4..7.
        got_q.delete();
        idx = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            cycle(idx < 5, 8'(idx + 1), 4'd1, 2'b00, !(cyc >= 4 && cyc <= 7), acc);
            if (acc) idx++;
            if (cyc >= 4 && cyc <= 7) begin
                chk("stall_out_valid", 32'(smp_ov), 32'(1));
                chk("stall_out", 32'(smp_out), 32'(8'h02));
                chk("stall_in_ready", 32'(smp_ir), 32'(0));
            end
        end
        chk("b2b_count", 32'(got_q.size()), 32'(5));
        for (int i = 0; i < got_q.size() && i < 5; i++)
            chk("b2b_order", 32'(got_q[i]), 32'(2 * (i + 1)));

        // Random traffic with random backpressure.
        pend = 1'b0; pa = 8'h00; pd = 4'd0; pm = 2'b00;
        for (int k = 0; k < 400; k++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                pa   = 8'($urandom);
                pd   = 4'($urandom_range(0, 15));
                pm   = 2'($urandom_range(0, 3));
            end
            cycle(pend, pa, pd, pm, $urandom_range(0, 3) != 0, acc);
            if (acc) pend = 1'b0;
        end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            cycle(1'b0, 8'h00, 4'd0, 2'b00, 1'b1, acc);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));

        // Reset with two operations in flight.
        cycle(1'b1, 8'h11, 4'd1, 2'b00, 1'b1, acc);
        cycle(1'b1, 8'h22, 4'd2, 2'b01, 1'b1, acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        single(8'h33, 4'd2, 2'b00, 8'hCC, 1'b0, "post_rst");
        for (int k = 0; k < 5; k++)
            cycle(1'b0, 8'h00, 4'd0, 2'b00, 1'b1, acc);
        chk("post_rst_idle", 32'(out_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
